// File: rtl/detector_emulator.sv
// Detector-side responder: measures trigger pulse width, then holds
// detector_ready low for a readout period and keeps trigger/error statistics.
//
// Ports:
//   clock, reset_signal        : system clock, async active-high reset
//   enable                     : emulator armed; low reports not ready
//   trigger_in                 : trigger level pulse (same clock domain)
//   clear                      : one-cycle clear of counters and sticky errors
//   detector_ready             : registered ready-for-trigger flag
//   trigger_count/missed_count : saturating statistics counters
//   error_short/error_stuck    : sticky protocol error flags
//   state                      : 0=IDLE 1=MEASURE 2=READOUT 3=STUCK
module detector_emulator #(
   parameter int MIN_TRIGGER_CYCLES = 10,
   parameter int MAX_TRIGGER_CYCLES = 1000,
   parameter int READOUT_CYCLES     = 1280000,
   parameter int COUNT_WIDTH        = 16
) (
   input  logic                   clock,
   input  logic                   reset_signal,
   input  logic                   enable,
   input  logic                   trigger_in,
   input  logic                   clear,
   output logic                   detector_ready,
   output logic [COUNT_WIDTH-1:0] trigger_count,
   output logic [COUNT_WIDTH-1:0] missed_count,
   output logic                   error_short,
   output logic                   error_stuck,
   output logic [1:0]             state
);

   localparam int WW = $clog2(MAX_TRIGGER_CYCLES + 1);
   localparam int RW = $clog2(READOUT_CYCLES + 1);

   localparam logic [WW-1:0] MIN_W    = WW'(MIN_TRIGGER_CYCLES);
   // width still reads MAX-1 on the edge that samples the MAX-th high cycle
   localparam logic [WW-1:0] STUCK_AT = WW'(MAX_TRIGGER_CYCLES - 1);
   localparam logic [RW-1:0] RO_LOAD  = RW'(READOUT_CYCLES);
   localparam logic [RW-1:0] RO_LAST  = RW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      READOUT = 2'd2,
      STUCK   = 2'd3
   } state_t;

   state_t             st;
   logic [WW-1:0]      width;
   logic [RW-1:0]      readout;
   logic               trig_prev;

   logic               rise;
   logic               accept_ev;
   logic               short_ev;
   logic               stuck_ev;
   logic               miss_ev;

   always_comb begin
      rise      = trigger_in & ~trig_prev;
      accept_ev = (st == MEASURE) && !trigger_in && (width >= MIN_W);
      short_ev  = (st == MEASURE) && !trigger_in && (width < MIN_W);
      stuck_ev  = (st == MEASURE) && trigger_in && (width == STUCK_AT);
      miss_ev   = rise && (st != IDLE);
   end

   assign state = st;

   always_ff @(posedge clock or posedge reset_signal) begin
      if (reset_signal) begin
         st             <= IDLE;
         detector_ready <= 1'b0;
         width          <= '0;
         readout        <= '0;
         trig_prev      <= 1'b0;
         trigger_count  <= '0;
         missed_count   <= '0;
         error_short    <= 1'b0;
         error_stuck    <= 1'b0;
      end else begin
         trig_prev <= trigger_in;

         unique case (st)
            IDLE: begin
               detector_ready <= enable;
               if (rise && enable) begin
                  st             <= MEASURE;
                  width          <= WW'(1);
                  detector_ready <= 1'b0;
               end
            end
            MEASURE: begin
               detector_ready <= 1'b0;
               if (trigger_in) begin
                  width <= width + WW'(1);
                  if (stuck_ev) st <= STUCK;
               end else if (accept_ev) begin
                  st      <= READOUT;
                  readout <= RO_LOAD;
               end else begin
                  // short pulse: back to idle without a readout period
                  st             <= IDLE;
                  detector_ready <= enable;
               end
            end
            READOUT: begin
               detector_ready <= 1'b0;
               readout        <= readout - RW'(1);
               if (readout == RO_LAST) begin
                  st             <= IDLE;
                  detector_ready <= enable;
               end
            end
            STUCK: begin
               detector_ready <= 1'b0;
               if (!trigger_in) begin
                  st             <= IDLE;
                  detector_ready <= enable;
               end
            end
         endcase

         // clear has priority over any same-cycle increment or error
         if (clear) begin
            trigger_count <= '0;
            missed_count  <= '0;
            error_short   <= 1'b0;
            error_stuck   <= 1'b0;
         end else begin
            if (accept_ev && (trigger_count != '1))
               trigger_count <= trigger_count + COUNT_WIDTH'(1);
            if (miss_ev && (missed_count != '1))
               missed_count <= missed_count + COUNT_WIDTH'(1);
            if (short_ev) error_short <= 1'b1;
            if (stuck_ev) error_stuck <= 1'b1;
         end
      end
   end

endmodule

// File: doc/detector_emulator.md
Name: detector_emulator

Overview:
Synthesizable detector-side responder for the calibration/scenario FSMs' output trigger and detector_ready handshake. It accepts a trigger pulse and measures its width. It then holds detector_ready low for a programmable readout time and reports trigger statistics and protocol errors. It is used in the bench and on hardware in place of a real detector to close the loop for self-test.

Parameters:
MIN_TRIGGER_CYCLES, 10, minimum accepted trigger width in clocks (50 ns at 200 MHz); must be >= 1
MAX_TRIGGER_CYCLES, 1000, trigger width at which the input is declared stuck; must be > MIN_TRIGGER_CYCLES
READOUT_CYCLES, 1280000, busy time after an accepted trigger (6400 us at 200 MHz); must be >= 1
COUNT_WIDTH, 16, width of the statistics counters

Ports:
clock  input  1  system clock, 200 MHz
reset_signal  input  1  asynchronous, active-high reset
enable  input  1  emulator armed; when low, the detector is reported not ready
trigger_in  input  1  trigger from the FSM, same clock domain, level pulse
clear  input  1  synchronous one-cycle clear of counters and sticky errors
detector_ready  output  1  high = ready to accept a trigger (registered)
trigger_count  output  COUNT_WIDTH  accepted triggers, saturating
missed_count  output  COUNT_WIDTH  rising edges seen while not in IDLE, saturating
error_short  output  1  sticky: pulse narrower than MIN_TRIGGER_CYCLES
error_stuck  output  1  sticky: pulse reached MAX_TRIGGER_CYCLES
state  output  2  0=IDLE, 1=MEASURE, 2=READOUT, 3=STUCK

Behaviour:
- Reset (async assert, sync release): state=IDLE, detector_ready=0, width/readout counters=0, trigger_count=0, missed_count=0, error_short=0, error_stuck=0, trig_prev=0.
- Rising edge = trigger_in=1 and trig_prev=1'b0; trig_prev is trigger_in registered every cycle.
- IDLE: detector_ready<=enable. Rising edge with enable=1 -> MEASURE, width<=1, detector_ready<=0. Rising edge with enable=0 is ignored and not counted.
- MEASURE: detector_ready=0.
  - trigger_in=1: width++. When width reaches MAX_TRIGGER_CYCLES -> STUCK, error_stuck<=1.
  - trigger_in=0 with width<MIN_TRIGGER_CYCLES -> IDLE, error_short<=1, no count.
  - trigger_in=0 with width>=MIN_TRIGGER_CYCLES -> READOUT, readout<=READOUT_CYCLES, trigger_count++ (saturating).
- Width equal to exactly MIN_TRIGGER_CYCLES is accepted.
- READOUT: detector_ready=0, readout-- each cycle. When readout=1 -> IDLE; detector_ready<=enable on that same edge.
  - Net effect: ready is low for exactly W + READOUT_CYCLES cycles after an accepted pulse of width W.
- STUCK: detector_ready=0. Leaves to IDLE on the first cycle trigger_in=0. Not counted.
- Rising edge in MEASURE (impossible), READOUT or STUCK: missed_count++ (saturating). The edge does not restart or extend readout.
- enable falling mid-operation: the current MEASURE/READOUT/STUCK sequence completes. Ready then stays 0 in IDLE.
- clear=1: counters and sticky errors go to 0 next edge; state and ready are unaffected.
- clear coinciding with an increment or error event: clear wins.
- Counters saturate at all-ones with no wrap.
- Width counter width is clog2(MAX_TRIGGER_CYCLES+1); readout counter width is clog2(READOUT_CYCLES+1).
- reset_signal mid-READOUT: immediate return to reset values. After release, ready rises 1 cycle later if enable=1.

Test Plan (MIN=4, MAX=64, READOUT=100, enable=1 unless stated):
1. Reset release, then 20-cycle trigger -> ready=1 one cycle after release. Ready falls on the edge sampling the rise, stays low 120 cycles, then returns to 1. trigger_count=1, state sequence 0->1->2->0.
2. 3-cycle pulse -> error_short=1, trigger_count=0, ready low 3 cycles. A following 4-cycle pulse is accepted: count=1, ready low 104 cycles.
3. 20-cycle pulse, then a 10-cycle pulse starting 30 cycles after the first falls -> missed_count=1, trigger_count=1. Ready still returns high exactly 100 cycles after the first fall.
4. Trigger held 200 cycles -> state=3 and error_stuck=1 after 64 cycles high. Ready stays 0 until trigger drops, then IDLE with ready=1 next cycle; trigger_count=0.
5. enable=0 with three 20-cycle pulses -> ready=0, state stays 0, all counters 0. Then set enable=1 and pulse clear during a 20-cycle pulse's MEASURE -> the pulse is still counted (count=1 after fall).
6. reset_signal asserted 50 cycles into READOUT -> outputs at reset values immediately (async). After release, ready=1 after one cycle and counters=0.
